counter_bounded: RTL and testbench
==================================

Name: counter_bounded

Overview:
- Parametrised up/down counter with runtime bound, variable step and selectable end-of-range mode (wrap, saturate, one-shot).
- Successor to the single-step up/down/load counter, which has only a compile-time saturate option.
- Used by the Sobel pipeline for pixel/line position tracking, window-fill counting and frame timing, where the limit and step are set at run time.

Parameters:
- WIDTH_P, 16, counter and bound width in bits (2..32).
- RESET_VAL_P, 0, count value after reset and after clear_i; must be <= the max_i in use.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rstn_i  input  1  synchronous active-low reset.
- en_i  input  1  count/load enable.
- clear_i  input  1  returns count to RESET_VAL_P; ignores en_i.
- load_i  input  1  load data_i; requires en_i.
- data_i  input  WIDTH_P  load value.
- up_i  input  1  count up by step_i.
- down_i  input  1  count down by step_i.
- step_i  input  WIDTH_P  increment magnitude; 0 = hold.
- max_i  input  WIDTH_P  inclusive upper bound; legal range is 0..max_i.
- mode_i  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as saturate).
- count_o  output  WIDTH_P  registered count.
- at_max_o  output  1  count_o == max_i (combinational from the register and max_i).
- at_zero_o  output  1  count_o == 0 (combinational from the register).
- wrap_o  output  1  registered one-cycle pulse: the last update wrapped or clipped at a bound.
- done_o  output  1  sticky one-shot terminal flag.

Behaviour:
- Reset (rstn_i low at a clock edge): count_o = RESET_VAL_P, wrap_o = 0, done_o = 0. Reset overrides all other inputs and may arrive mid-count.
- Priority per edge: reset > clear_i > load_i > counting.
- clear_i: count = RESET_VAL_P, done_o = 0, wrap_o = 0; ignores en_i.
- en_i low (no clear): count_o and done_o hold; wrap_o = 0.
- load_i with en_i:
  - count = min(data_i, max_i); done_o = 0; wrap_o = 0.
  - up_i and down_i are ignored that cycle.
- Counting (en_i = 1, no clear, no load):
  - Direction is up when up_i & ~down_i, down when down_i & ~up_i.
  - Both or neither asserted: hold, wrap_o = 0.
  - done_o = 1 in one-shot mode: hold; the only exits are load, clear or reset.
- Arithmetic: computed at WIDTH_P+1 bits so sums never overflow internally.
  - Up: s = count + step_i. If s <= max_i, count = s. Otherwise it is a bound event.
  - Down: if count >= step_i, count = count - step_i. Otherwise it is a bound event.
- Bound event, up direction:
  - wrap: count = s - (max_i + 1).
  - saturate: count = max_i.
  - one-shot: count = max_i and done_o = 1.
- Bound event, down direction:
  - wrap: count = count + (max_i + 1) - step_i.
  - saturate: count = 0.
  - one-shot: count = 0 and done_o = 1.
- wrap_o = 1 on the edge after any bound event, aligned with the new count_o. It is not raised when count lands exactly on max_i or 0 without crossing.
- Legal step: step_i must be <= max_i + 1. Larger values are illegal; a simulation assertion fires and the result is unspecified.
- max_i = 0:
  - The count stays 0.
  - Any nonzero step is a bound event; in wrap mode this gives a wrap_o pulse each enabled cycle.
- max_i lowered below the current count: on the next enabled count cycle, up is a bound event. Down proceeds arithmetically and is not re-clipped. Loading re-clamps.
- mode_i changing mid-count: takes effect on the next edge. Leaving one-shot mode does not clear done_o.
- Latency: one cycle from inputs to count_o, wrap_o and done_o. at_max_o and at_zero_o follow count_o in the same cycle.

Test Plan:
- Reset and hold: WIDTH_P=8, RESET_VAL_P=0; reset, then en_i=0 with up_i=1 for 5 cycles -> count_o=0, at_zero_o=1, wrap_o=0, done_o=0.
- Wrap with step: max_i=9, step_i=3, mode=wrap, up for 4 cycles -> count 3, 6, 9, 2; wrap_o pulses only with 2. Then down with step 3 from 2 -> 9, with wrap_o=1.
- Saturate both ends: max_i=200, load 198, step 5 up -> 200 with wrap_o=1, at_max_o=1; further up holds at 200. Down step 5 from 3 -> 0 with wrap_o=1.
- One-shot: max_i=4, step 1, mode=one-shot, up from 0 -> 1, 2, 3, 4, then 4 with done_o=1. Further up holds. load data_i=2 -> count 2, done_o=0.
- Priority and clamp:
  - clear_i=1 with load_i=1, en_i=0 -> count=RESET_VAL_P.
  - load data_i=250 with max_i=100 -> count 100.
  - up_i=down_i=1 -> hold.
- Reset mid-operation: counting in wrap mode at count 7, done_o=1 from a prior one-shot; rstn_i low for 1 cycle -> count 0, done_o 0, wrap_o 0 at the next edge; counting resumes after release.

Source files
------------

// File: rtl/counter_bounded.sv
// Up/down counter with a runtime inclusive bound, variable step and a
// selectable end-of-range policy (wrap, saturate, one-shot).
module counter_bounded #(
  parameter int WIDTH_P     = 16,
  parameter int RESET_VAL_P = 0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [WIDTH_P-1:0] step_i,
  input  logic [WIDTH_P-1:0] max_i,
  input  logic [1:0]         mode_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               at_max_o,
  output logic               at_zero_o,
  output logic               wrap_o,
  output logic               done_o
);

  localparam logic [WIDTH_P-1:0] RESET_COUNT = RESET_VAL_P[WIDTH_P-1:0];
  localparam logic [WIDTH_P:0]   ONE_EXT     = {{WIDTH_P{1'b0}}, 1'b1};

  logic [WIDTH_P-1:0] count_reg, count_next;
  logic               wrap_reg, wrap_next;
  logic               done_reg, done_next;

  logic [WIDTH_P:0] count_ext, step_ext, max_ext, max_p1;
  logic [WIDTH_P:0] sum_up, wrap_up, wrap_dn;
  logic             up_dir, down_dir, is_wrap, is_oneshot;
  logic             count_active;

  // Arithmetic is one bit wider than the counter so sums never overflow.
  assign count_ext = {1'b0, count_reg};
  assign step_ext  = {1'b0, step_i};
  assign max_ext   = {1'b0, max_i};
  assign max_p1    = max_ext + ONE_EXT;
  assign sum_up    = count_ext + step_ext;
  assign wrap_up   = sum_up - max_p1;
  assign wrap_dn   = count_ext + max_p1 - step_ext;

  assign up_dir     = up_i & ~down_i;
  assign down_dir   = down_i & ~up_i;
  assign is_wrap    = (mode_i == 2'b00);
  assign is_oneshot = (mode_i == 2'b10);

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    done_next  = done_reg;
    if (clear_i) begin
      count_next = RESET_COUNT;
      done_next  = 1'b0;
    end else if (!en_i) begin
      count_next = count_reg;
    end else if (load_i) begin
      count_next = (data_i > max_i) ? max_i : data_i;
      done_next  = 1'b0;
    end else if (is_oneshot && done_reg) begin
      count_next = count_reg;
    end else if (up_dir) begin
      if (sum_up <= max_ext) begin
        count_next = sum_up[WIDTH_P-1:0];
      end else begin
        wrap_next = 1'b1;
        if (is_wrap) begin
          count_next = wrap_up[WIDTH_P-1:0];
        end else begin
          count_next = max_i;
          done_next  = done_reg | is_oneshot;
        end
      end
    end else if (down_dir) begin
      if (count_reg >= step_i) begin
        count_next = count_reg - step_i;
      end else begin
        wrap_next = 1'b1;
        if (is_wrap) begin
          count_next = wrap_dn[WIDTH_P-1:0];
        end else begin
          count_next = '0;
          done_next  = done_reg | is_oneshot;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_reg <= RESET_COUNT;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      done_reg  <= done_next;
    end
  end

  assign count_o   = count_reg;
  assign at_max_o  = (count_reg == max_i);
  assign at_zero_o = (count_reg == '0);
  assign wrap_o    = wrap_reg;
  assign done_o    = done_reg;

  // Steps larger than max_i + 1 can skip a whole range and have no defined result.
  assign count_active = en_i & ~clear_i & ~load_i & (up_dir | down_dir);

  step_legal_a : assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_active |-> (step_ext <= max_p1));

endmodule

// File: tb/tb_counter_bounded.sv
// Directed-vector bench for counter_bounded (WIDTH_P=8, RESET_VAL_P=0).
module tb_counter_bounded;

  localparam int W = 8;
  localparam logic [1:0] MW = 2'b00, MS = 2'b01, MO = 2'b10;

  logic         clk = 1'b0;
  logic         rstn, en, clr, ld, up, dn;
  logic [W-1:0] data, step, maxv;
  logic [1:0]   mode;
  logic [W-1:0] count;
  logic         at_max, at_zero, wrap, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rstn, en, clr, ld;
    logic [W-1:0] data;
    logic         up, dn;
    logic [W-1:0] step, maxv;
    logic [1:0]   mode;
    logic [W-1:0] e_cnt;
    logic         e_amax, e_az, e_wrap, e_done;
  } vec_t;

  vec_t vecs[$];

  counter_bounded #(.WIDTH_P(W), .RESET_VAL_P(0)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clear_i(clr), .load_i(ld),
    .data_i(data), .up_i(up), .down_i(dn), .step_i(step), .max_i(maxv),
    .mode_i(mode), .count_o(count), .at_max_o(at_max), .at_zero_o(at_zero),
    .wrap_o(wrap), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, e, c, l, input int d, input logic u, dw,
                     input int st, mx, input logic [1:0] md,
                     input int ec, input logic eam, eaz, ew, ed);
    vec_t v;
    v.rstn = r; v.en = e; v.clr = c; v.ld = l; v.data = d[W-1:0];
    v.up = u; v.dn = dw; v.step = st[W-1:0]; v.maxv = mx[W-1:0]; v.mode = md;
    v.e_cnt = ec[W-1:0]; v.e_amax = eam; v.e_az = eaz; v.e_wrap = ew; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rstn = v.rstn; en = v.en; clr = v.clr; ld = v.ld; data = v.data;
    up = v.up; dn = v.dn; step = v.step; maxv = v.maxv; mode = v.mode;
    @(posedge clk);
    #1;
    chk("count",   idx, int'(count),   int'(v.e_cnt));
    chk("at_max",  idx, int'(at_max),  int'(v.e_amax));
    chk("at_zero", idx, int'(at_zero), int'(v.e_az));
    chk("wrap",    idx, int'(wrap),    int'(v.e_wrap));
    chk("done",    idx, int'(done),    int'(v.e_done));
    $display("vec %0d: count=%0d at_max=%0d at_zero=%0d wrap=%0d done=%0d",
             idx, count, at_max, at_zero, wrap, done);
  endtask

  initial begin
    rstn = 0; en = 0; clr = 0; ld = 0; data = '0; up = 0; dn = 0;
    step = '0; maxv = '0; mode = MW;

    // reset, then disabled with up asserted
    add(0,0,0,0,  0,1,0, 3,  9,MW,   0,0,1,0,0);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,0,1,0, 3,  9,MW,   0,0,1,0,0);
    // wrap with step 3, max 9
    add(1,1,0,0,  0,1,0, 3,  9,MW,   3,0,0,0,0);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   6,0,0,0,0);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   9,1,0,0,0);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   2,0,0,1,0);
    add(1,1,0,0,  0,0,1, 3,  9,MW,   9,1,0,1,0);
    add(1,1,0,0,  0,0,1, 3,  9,MW,   6,0,0,0,0);
    // saturate both ends, max 200
    add(1,1,0,1,198,0,0, 5,200,MS, 198,0,0,0,0);
    add(1,1,0,0,  0,1,0, 5,200,MS, 200,1,0,1,0);
    add(1,1,0,0,  0,1,0, 5,200,MS, 200,1,0,1,0);
    add(1,1,0,1,195,0,0, 5,200,MS, 195,0,0,0,0);
    add(1,1,0,0,  0,1,0, 5,200,MS, 200,1,0,0,0);
    add(1,1,0,1,  3,0,0, 5,200,MS,   3,0,0,0,0);
    add(1,1,0,0,  0,0,1, 5,200,MS,   0,0,1,1,0);
    add(1,1,0,0,  0,0,1, 5,200,MS,   0,0,1,1,0);
    add(1,1,0,0,  0,0,1, 0,200,MS,   0,0,1,0,0);
    // one-shot, max 4
    add(1,1,1,0,  0,0,0, 1,  4,MO,   0,0,1,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   1,0,0,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   2,0,0,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   3,0,0,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   4,1,0,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   4,1,0,1,1);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   4,1,0,0,1);
    add(1,1,0,0,  0,0,1, 1,  4,MO,   4,1,0,0,1);
    add(1,1,0,1,  2,0,0, 1,  4,MO,   2,0,0,0,0);
    // priority and clamp
    add(1,0,1,1, 50,0,0, 1,100,MS,   0,0,1,0,0);
    add(1,1,0,1,250,0,0, 1,100,MS, 100,1,0,0,0);
    add(1,1,0,0,  0,1,1, 1,100,MS, 100,1,0,0,0);
    add(1,1,0,0,  0,1,0, 1,100,MS, 100,1,0,1,0);
    add(1,0,0,0,  0,1,0, 1,100,MS, 100,1,0,0,0);
    // max 0 in wrap mode
    add(1,1,1,0,  0,0,0, 1,  0,MW,   0,1,1,0,0);
    add(1,1,0,0,  0,1,0, 1,  0,MW,   0,1,1,1,0);
    add(1,1,0,0,  0,1,0, 1,  0,MW,   0,1,1,1,0);
    add(1,1,0,0,  0,0,1, 1,  0,MW,   0,1,1,1,0);
    // max lowered below count: down not re-clipped, up clips
    add(1,1,0,1, 50,0,0, 1,100,MS,  50,0,0,0,0);
    add(1,1,0,0,  0,0,1, 5, 20,MS,  45,0,0,0,0);
    add(1,1,0,0,  0,1,0, 1, 20,MS,  20,1,0,1,0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // reset mid-operation with done set from an earlier one-shot
    vecs.delete();
    add(1,1,0,1,  4,0,0, 1,  4,MO,   4,1,0,0,0);
    add(1,1,0,0,  0,1,0, 1,  4,MO,   4,1,0,1,1);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   7,0,0,0,1);
    add(0,1,0,0,  0,1,0, 3,  9,MW,   0,0,1,0,0);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   3,0,0,0,0);
    add(1,1,0,0,  0,1,0, 3,  9,MW,   6,0,0,0,0);
    apply(vecs[0], 100);
    apply(vecs[1], 101);
    apply(vecs[2], 102);
    apply(vecs[3], 103);
    apply(vecs[4], 104);
    apply(vecs[5], 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
